// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared types and constants for the HD44780-style character
//               LCD controller: FSM states, init ROM, command-word layout.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

   // Controller sequencing states
   typedef enum logic [2:0] {
      ST_PWRUP      = 3'd0,
      ST_INIT_ISSUE = 3'd1,
      ST_IDLE       = 3'd2,
      ST_SETUP      = 3'd3,
      ST_PULSE      = 3'd4,
      ST_HOLD       = 3'd5,
      ST_WAIT       = 3'd6
   } lcd_state_e;

   // Power-up initialisation sequence: 8-bit/2-line function set (x3),
   // display on, clear, entry mode increment. All issued with RS=0.
   localparam int unsigned LCD_INIT_LEN = 6;
   localparam logic [7:0]  LCD_INIT_SEQ [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

   // Command-word field positions
   localparam int unsigned CMD_ON_BIT   = 31;
   localparam int unsigned CMD_BLON_BIT = 30;
   localparam int unsigned CMD_RS_BIT   = 9;
   localparam int unsigned CMD_DATA_MSB = 7;
   localparam int unsigned CMD_DATA_LSB = 0;

   // Instruction codes that need the long execution wait
   localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
   localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

   // Clear and return-home are the only slow instructions (data writes never are)
   function automatic logic lcd_is_long(input logic rs, input logic [7:0] data);
      return !rs && ((data == LCD_CMD_CLEAR) || (data == LCD_CMD_HOME));
   endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lcd_ctrl
// Description : Write-only HD44780 8-bit bus controller. Runs the power-up
//               init sequence after reset, then accepts 32-bit command words
//               and sequences them as setup / EN pulse / hold / exec wait.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_ctrl
   import lcd_pkg::*;
#(
   parameter int unsigned T_PWRUP_CYC = 750000,
   parameter int unsigned T_SETUP_CYC = 2,
   parameter int unsigned T_EN_CYC    = 12,
   parameter int unsigned T_HOLD_CYC  = 2,
   parameter int unsigned T_EXEC_CYC  = 2000,
   parameter int unsigned T_LONG_CYC  = 82000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        cmd_valid_i,
   input  logic [31:0] cmd_data_i,
   output logic        cmd_ready_o,
   output logic        init_done_o,
   output logic [7:0]  lcd_data_o,
   output logic        lcd_rs_o,
   output logic        lcd_rw_o,
   output logic        lcd_en_o,
   output logic        lcd_on_o,
   output logic        lcd_blon_o
);

   // The power-up wait is by far the longest phase, so it sizes the shared counter
   localparam int CNT_W = $clog2(T_PWRUP_CYC + 1);

   // A phase of T cycles loads T-1 and advances on the cycle the counter is 0
   function automatic logic [CNT_W-1:0] phase_load(input int unsigned t);
      return CNT_W'(t - 1);
   endfunction

   lcd_state_e       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_init_idx;
   logic [7:0]       r_data;
   logic             r_rs;
   logic             r_en;
   logic             r_on;
   logic             r_blon;
   logic             r_ready;
   logic             r_init_done;

   logic             w_accept;
   logic             w_cnt_zero;
   logic             w_long;
   logic             w_last_init;
   logic [21:0]      w_unused_bits;

   // Handshake, phase-expiry and wait-length selection
   assign w_accept      = cmd_valid_i & r_ready;
   assign w_cnt_zero    = (r_cnt == '0);
   assign w_long        = lcd_is_long(r_rs, r_data);
   assign w_last_init   = (r_init_idx == 3'(LCD_INIT_LEN - 1));
   assign w_unused_bits = {cmd_data_i[29:10], cmd_data_i[8], 1'b0};

   // Single FSM with the shared down-counter; every output comes from a flop here
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= ST_PWRUP;
         r_cnt       <= phase_load(T_PWRUP_CYC);
         r_init_idx  <= 3'd0;
         r_data      <= 8'h00;
         r_rs        <= 1'b0;
         r_en        <= 1'b0;
         r_on        <= 1'b0;
         r_blon      <= 1'b0;
         r_ready     <= 1'b0;
         r_init_done <= 1'b0;
      end else begin
         case (r_state)
            ST_PWRUP: begin
               // Panel power and backlight come up immediately; bus stays quiet
               r_on   <= 1'b1;
               r_blon <= 1'b1;
               if (w_cnt_zero) begin
                  r_init_idx <= 3'd0;
                  r_state    <= ST_INIT_ISSUE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end

            ST_INIT_ISSUE: begin
               r_data  <= LCD_INIT_SEQ[r_init_idx];
               r_rs    <= 1'b0;
               r_cnt   <= phase_load(T_SETUP_CYC);
               r_state <= ST_SETUP;
            end

            ST_IDLE: begin
               if (w_accept) begin
                  r_rs    <= cmd_data_i[CMD_RS_BIT];
                  r_data  <= cmd_data_i[CMD_DATA_MSB:CMD_DATA_LSB];
                  r_on    <= cmd_data_i[CMD_ON_BIT];
                  r_blon  <= cmd_data_i[CMD_BLON_BIT];
                  r_ready <= 1'b0;
                  r_cnt   <= phase_load(T_SETUP_CYC);
                  r_state <= ST_SETUP;
               end
            end

            ST_SETUP: begin
               if (w_cnt_zero) begin
                  r_en    <= 1'b1;
                  r_cnt   <= phase_load(T_EN_CYC);
                  r_state <= ST_PULSE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end

            ST_PULSE: begin
               if (w_cnt_zero) begin
                  r_en    <= 1'b0;
                  r_cnt   <= phase_load(T_HOLD_CYC);
                  r_state <= ST_HOLD;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end

            ST_HOLD: begin
               if (w_cnt_zero) begin
                  r_cnt   <= w_long ? phase_load(T_LONG_CYC) : phase_load(T_EXEC_CYC);
                  r_state <= ST_WAIT;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end

            ST_WAIT: begin
               if (w_cnt_zero) begin
                  if (r_init_done) begin
                     r_ready <= 1'b1;
                     r_state <= ST_IDLE;
                  end else if (w_last_init) begin
                     r_init_done <= 1'b1;
                     r_ready     <= 1'b1;
                     r_state     <= ST_IDLE;
                  end else begin
                     r_init_idx <= r_init_idx + 3'd1;
                     r_state    <= ST_INIT_ISSUE;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end

            default: begin
               r_state <= ST_PWRUP;
               r_cnt   <= phase_load(T_PWRUP_CYC);
            end
         endcase
      end
   end

   assign cmd_ready_o = r_ready;
   assign init_done_o = r_init_done;
   assign lcd_data_o  = r_data;
   assign lcd_rs_o    = r_rs;
   assign lcd_rw_o    = 1'b0;
   assign lcd_en_o    = r_en;
   assign lcd_on_o    = r_on;
   assign lcd_blon_o  = r_blon;

endmodule
`default_nettype wire

// File: tb/tb_lcd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_ctrl
// Description : Scoreboard bench for lcd_ctrl. The stimulus side predicts
//               every EN pulse from the command timing rules and queues it;
//               a monitor pops and checks on each observed EN edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_ctrl;

   localparam int T_PWRUP = 100;
   localparam int S       = 2;
   localparam int E       = 4;
   localparam int H       = 2;
   localparam int T_EXEC  = 10;
   localparam int T_LONG  = 50;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        cmd_valid_i = 1'b0;
   logic [31:0] cmd_data_i = 32'h0;
   logic        cmd_ready_o, init_done_o, lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_on_o, lcd_blon_o;
   logic [7:0]  lcd_data_o;

   lcd_ctrl #(
      .T_PWRUP_CYC(T_PWRUP), .T_SETUP_CYC(S), .T_EN_CYC(E),
      .T_HOLD_CYC(H), .T_EXEC_CYC(T_EXEC), .T_LONG_CYC(T_LONG)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .cmd_valid_i(cmd_valid_i), .cmd_data_i(cmd_data_i),
      .cmd_ready_o(cmd_ready_o), .init_done_o(init_done_o), .lcd_data_o(lcd_data_o),
      .lcd_rs_o(lcd_rs_o), .lcd_rw_o(lcd_rw_o), .lcd_en_o(lcd_en_o),
      .lcd_on_o(lcd_on_o), .lcd_blon_o(lcd_blon_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic       rs;
      logic [7:0] data;
      logic       on;
      logic       blon;
      int         rise;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   k;              // clock edges since reset release
   int   m_free;         // model: ready is high after edge k when k >= m_free
   int   m_init_end;     // model: edge after which init_done is high

   // Edge counter restarts with every reset
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) k <= 0;
      else         k <= k + 1;
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, k);
      end
   endtask

   // Reference timing: execution wait depends only on the instruction kind
   function automatic int exec_len(input logic rs, input logic [7:0] d);
      return (!rs && (d == 8'h01 || d == 8'h02)) ? T_LONG : T_EXEC;
   endfunction

   // New epoch after reset release: predict the whole init sequence
   task automatic start_epoch();
      logic [7:0] rom [6];
      int t;
      rom = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
      q.delete();
      t = T_PWRUP;
      for (int i = 0; i < 6; i++) begin
         q.push_back('{rs: 1'b0, data: rom[i], on: 1'b1, blon: 1'b1, rise: t + 1 + S});
         t = t + 1 + S + E + H + exec_len(1'b0, rom[i]);
      end
      m_init_end = t;
      m_free     = t;
   endtask

   // One driver cycle: present (v,d) to the next edge and predict acceptance
   task automatic step(input logic v, input logic [31:0] d, output int acc_edge);
      @(negedge clk_i);
      #1;
      cmd_valid_i = v;
      cmd_data_i  = d;
      acc_edge    = -1;
      if (v && k >= m_free) begin
         acc_edge = k + 1;
         q.push_back('{rs: d[9], data: d[7:0], on: d[31], blon: d[30], rise: acc_edge + S});
         m_free = acc_edge + S + E + H + exec_len(d[9], d[7:0]);
      end
   endtask

   task automatic idle(input int n);
      int a;
      for (int i = 0; i < n; i++) step(1'b0, 32'h0, a);
   endtask

   task automatic send(input logic [31:0] d, output int acc_edge);
      int a;
      acc_edge = -1;
      for (int i = 0; i < 200 && acc_edge < 0; i++) begin
         step(1'b1, d, a);
         acc_edge = a;
      end
      if (acc_edge < 0) check("send_timeout", 0, 1);
      step(1'b0, 32'h0, a);
   endtask

   // Monitor: per-cycle status checks and EN-edge scoreboard checks
   exp_t cur;
   logic prev_en = 1'b0;
   int   rise_k  = 0;
   always @(negedge clk_i) begin
      if (!rst_ni) begin
         prev_en = 1'b0;
      end else begin
         check("rw_low", lcd_rw_o, 0);
         check("ready", cmd_ready_o, (k >= m_free) ? 1 : 0);
         check("init_done", init_done_o, (k >= m_init_end) ? 1 : 0);
         if (lcd_en_o && !prev_en) begin
            if (q.size() == 0) begin
               check("unexpected_en", 1, 0);
            end else begin
               cur    = q.pop_front();
               rise_k = k;
               check("en_rise_edge", k, cur.rise);
               check("rise_rs", lcd_rs_o, cur.rs);
               check("rise_data", lcd_data_o, cur.data);
               check("rise_on_blon", {lcd_on_o, lcd_blon_o}, {cur.on, cur.blon});
            end
         end
         if (!lcd_en_o && prev_en) begin
            check("en_width", k - rise_k, E);
            check("hold_rs_data", {lcd_rs_o, lcd_data_o}, {cur.rs, cur.data});
         end
         prev_en = lcd_en_o;
      end
   end

   initial begin
      int a;
      logic [31:0] d;

      // Reset state
      #23;
      check("reset_outputs",
            {cmd_ready_o, init_done_o, lcd_data_o, lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_on_o, lcd_blon_o}, 0);
      @(negedge clk_i);
      #1;
      rst_ni = 1'b1;
      start_epoch();

      // Valid held from well before init completes; accepted right after
      idle(190);
      for (int i = 0; i < 80; i++) step(1'b1, 32'h8000_0155, a);
      // Valid held with changing data while busy
      for (int i = 0; i < 60; i++) step(1'b1, {$urandom} & 32'hC000_03FF | 32'h0000_0200, a);
      idle(70);

      // Directed words: data write, then a clear with backlight
      send(32'h8000_0241, a);
      send(32'hC000_0001, a);
      send(32'h4000_0002, a);

      // Randomized mix, biased toward slow instructions now and then
      for (int i = 0; i < 1500; i++) begin
         d = $urandom;
         if ($urandom_range(0, 7) == 0) begin
            d[9]   = 1'b0;
            d[7:0] = 8'($urandom_range(1, 2));
         end
         step(($urandom_range(0, 3) != 0), d, a);
      end

      // Reset while EN is high
      for (int i = 0; i < 200 && k < m_free; i++) idle(1);
      send(32'h8000_0230, a);
      while (k < a + S + 1) idle(1);
      check("en_before_reset", lcd_en_o, 1);
      #1;
      rst_ni = 1'b0;
      #1;
      check("async_reset_outputs",
            {cmd_ready_o, init_done_o, lcd_data_o, lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_on_o, lcd_blon_o}, 0);
      q.delete();
      repeat (3) @(negedge clk_i);
      #1;
      rst_ni = 1'b1;
      start_epoch();
      idle(260);
      send(32'hC000_0248, a);

      // Drain, bounded
      for (int i = 0; i < 500 && (q.size() != 0 || k < m_free); i++) idle(1);
      idle(3);
      check("queue_empty", q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/lcd_ctrl.md
# lcd_ctrl

Peripheral-side controller for the character LCD (HD44780-compatible, 8-bit bus, write-only). It accepts 32-bit command words that the load/store unit stores to the LCD output register. It sequences each word onto the LCD pins with the required setup, enable-pulse, hold and execution delays. After reset it runs the LCD power-up and initialisation sequence on its own. It sits between the LSU's LCD output register and the board's LCD pins.

## Interface
Parameters:
- `T_PWRUP_CYC`, default 750000: power-up wait in cycles (15 ms at 50 MHz).
- `T_SETUP_CYC`, default 2: RS/DATA setup before EN rises.
- `T_EN_CYC`, default 12: EN high width.
- `T_HOLD_CYC`, default 2: RS/DATA hold after EN falls.
- `T_EXEC_CYC`, default 2000: normal command/data execution wait (40 µs).
- `T_LONG_CYC`, default 82000: clear/home execution wait (1.64 ms).

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `cmd_valid_i`, in, 1: command word present.
- `cmd_data_i`, in, 32: command word.
  - [31] ON; [30] BLON; [9] RS; [7:0] DATA.
  - All other bits are ignored.
- `cmd_ready_o`, out, 1: controller can accept a word.
- `init_done_o`, out, 1: initialisation sequence complete.
- `lcd_data_o`, out, 8: LCD data bus.
- `lcd_rs_o`, out, 1: register select.
- `lcd_rw_o`, out, 1: read/write; always 0.
- `lcd_en_o`, out, 1: enable strobe.
- `lcd_on_o`, out, 1: LCD power.
- `lcd_blon_o`, out, 1: backlight.

## Operation
- All outputs are registered. Reset value of every output is 0.
- FSM states: PWRUP, INIT_ISSUE, IDLE, SETUP, PULSE, HOLD, WAIT. One shared down-counter, sized `$clog2(T_PWRUP_CYC+1)`.
- PWRUP:
  - Entered on reset release.
  - `lcd_on_o`/`lcd_blon_o` = 1 from the first cycle after release.
  - Counts `T_PWRUP_CYC`, then goes to INIT_ISSUE with init index = 0.
- INIT_ISSUE:
  - Loads ROM entry[index] (RS=0) into the output register, then goes to SETUP.
  - ROM contents: 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06.
- Handshake:
  - `cmd_ready_o` = 1 only in IDLE with `init_done_o` = 1.
  - A transfer occurs when `cmd_valid_i & cmd_ready_o` is sampled at a clock edge.
  - On transfer: RS, DATA, ON and BLON are latched and the FSM goes to SETUP.
  - `cmd_valid_i` is ignored whenever ready = 0; no queuing.
- SETUP: `lcd_rs_o`/`lcd_data_o` driven, EN=0, for `T_SETUP_CYC` cycles.
- PULSE: EN=1 for `T_EN_CYC` cycles.
- HOLD: EN=0, RS/DATA unchanged, for `T_HOLD_CYC` cycles.
- WAIT:
  - RS/DATA unchanged.
  - Waits `T_LONG_CYC` if RS=0 and DATA is 0x01 or 0x02; otherwise waits `T_EXEC_CYC`.
  - Exit while init is in progress: index+1 → INIT_ISSUE. After index 5, sets `init_done_o`=1 and goes to IDLE.
  - Exit after init: IDLE.
- Width rule: counter loads (T−1) and the state advances when the counter reaches 0. Each phase lasts exactly T cycles, T ≥ 1.
- Reset mid-operation (any state):
  - All outputs return to 0 immediately (asynchronous).
  - The in-flight word is lost.
  - Init restarts from PWRUP after release.
- `init_done_o`, once set, stays 1 until reset.

## Timing
- Accept at edge N: `cmd_ready_o` = 0 and the SETUP outputs are valid after edge N.
- EN rises after edge N+`T_SETUP_CYC`.
- EN falls after edge N+`T_SETUP_CYC`+`T_EN_CYC`.
- `cmd_ready_o` = 1 again after edge N+S+E+H+W, where S, E, H, W are the four phase lengths.
- Back-to-back: the next word can be accepted on the same edge on which ready is first high.
- Init sequence: `init_done_o` rises T_PWRUP + 6·(1+S+E+H) + 5·T_EXEC + T_LONG cycles after release. The +1 per command is the INIT_ISSUE cycle.

## Structure
- Package `lcd_pkg` holds:
  - the state enum `lcd_state_e`;
  - the init ROM constant array `LCD_INIT_SEQ[6]`;
  - command-word field positions (ON=31, BLON=30, RS=9, DATA=7:0);
  - codes `LCD_CMD_CLEAR`=0x01 and `LCD_CMD_HOME`=0x02.
- Single module with no sub-modules.
- Timing counter and FSM kept together.

## Test plan
Bench parameters: T_PWRUP=100, S=2, E=4, H=2, T_EXEC=10, T_LONG=50.
1. Reset release:
   - EN stays 0 for 100 cycles.
   - Six EN pulses follow, each 4 cycles wide, carrying DATA 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 with RS=0.
   - `init_done_o` rises 100+6·9+5·10+50 = 254 cycles after release.
   - `lcd_rw_o` = 0 throughout.
2. Write 0x8000_0241 after init:
   - RS=1, DATA=0x41, ON=1, BLON=0.
   - EN high on cycles 3–6 after accept.
   - Ready returns 18 cycles after accept.
3. Write 0xC000_0001:
   - Long wait applies; ready returns 58 cycles after accept.
   - BLON=1.
4. Hold valid with changing data during busy:
   - Only the word present at the ready edge is transferred.
   - Two words back-to-back produce two EN pulses 18 cycles apart.
5. Assert `rst_ni` in PULSE:
   - EN and all outputs read 0 within the same cycle.
   - After release, the full init sequence repeats.
6. Valid asserted before `init_done_o`:
   - Ready stays 0 and nothing is transferred.
   - The word is accepted on the first cycle after init completes.
